// File: rtl/matmul_apb_master.sv
// Purpose: command-driven APB4 requester that turns single read/write commands into SETUP/ACCESS transfers.
// Latency: command accepted at edge T -> SETUP at T+1, ACCESS at T+2, response valid at T+3 plus one cycle per pready_i-low cycle.
// Backpressure: cmd_ready_o is high only in IDLE; a held response (rsp_ready_i low) stalls acceptance of the next command.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   cmd_*                                valid/ready command channel (write, addr, wdata, strb)
//   rsp_*                                valid/ready response channel (rdata, err, timeout)
//   psel_o..pstrb_o, pready_i..prdata_i  APB4 requester port
//   txn_cnt_o                            completed transfers, wrapping
//   err_cnt_o                            errored transfers, saturating
// Optional feature: define MATMUL_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC
// consecutive pready_i-low cycles; otherwise ACCESS waits indefinitely.
module matmul_apb_master #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [STRB_W-1:0] cmd_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic [STRB_W-1:0] pstrb_o,
    input  logic              pready_i,
    input  logic              pslverr_i,
    input  logic [DATA_W-1:0] prdata_i,
    output logic [15:0]       txn_cnt_o,
    output logic [15:0]       err_cnt_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [15:0]       txn_cnt_q, txn_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        txn_cnt_d     = txn_cnt_q;
        err_cnt_d     = err_cnt_q;
`ifdef MATMUL_APB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write_i;
                    paddr_d  = cmd_addr_i;
                    // Reads never present stale write data or strobes on the bus.
                    pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d  = cmd_write_i ? cmd_strb_i  : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef MATMUL_APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready_i is checked first so a completion on the terminal cycle wins over the abort.
                if (pready_i) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    txn_cnt_d     = txn_cnt_q + 16'd1;
                    if (pslverr_i && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
`ifdef MATMUL_APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from the next state so ready never looks at cmd_valid_i combinationally.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            txn_cnt_q     <= '0;
            err_cnt_q     <= '0;
`ifdef MATMUL_APB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            txn_cnt_q     <= txn_cnt_d;
            err_cnt_q     <= err_cnt_d;
`ifdef MATMUL_APB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign txn_cnt_o     = txn_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master: write, waited read, slave error with held
// response, reset during ACCESS, and the stuck-pready case (timeout or indefinite wait).
module tb_matmul_apb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [15:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic        pslverr_i;
    logic [31:0] prdata_i;
    logic [15:0] txn_cnt_o;
    logic [15:0] err_cnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    matmul_apb_master #(
        .ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYC(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
        .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o)
    );

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
        chk("rst_psel",      32'(psel_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_txn",       32'(txn_cnt_o), 0);
        chk("rst_err",       32'(err_cnt_o), 0);
        rst_i = 1'b0;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready_o), 1);

        // Write 0x12345678 to 0x010, zero-wait completer
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h0010;
        cmd_wdata_i = 32'h1234_5678; cmd_strb_i = 4'hF;
        rsp_ready_i = 1'b1; pready_i = 1'b1;
        tick();                                    // T+1: SETUP
        cmd_valid_i = 1'b0;
        chk("wr_setup_psel",    32'(psel_o), 1);
        chk("wr_setup_penable", 32'(penable_o), 0);
        chk("wr_setup_cmdrdy",  32'(cmd_ready_o), 0);
        chk("wr_paddr",         32'(paddr_o), 32'h10);
        chk("wr_pwrite",        32'(pwrite_o), 1);
        chk("wr_pwdata",        pwdata_o, 32'h1234_5678);
        chk("wr_pstrb",         32'(pstrb_o), 32'hF);
        tick();                                    // T+2: ACCESS
        chk("wr_acc_psel",    32'(psel_o), 1);
        chk("wr_acc_penable", 32'(penable_o), 1);
        chk("wr_acc_rspv",    32'(rsp_valid_o), 0);
        tick();                                    // T+3: RESP
        chk("wr_rsp_psel",    32'(psel_o), 0);
        chk("wr_rsp_penable", 32'(penable_o), 0);
        chk("wr_rsp_valid",   32'(rsp_valid_o), 1);
        chk("wr_rsp_err",     32'(rsp_err_o), 0);
        chk("wr_rsp_rdata",   rsp_rdata_o, 0);
        chk("wr_txn",         32'(txn_cnt_o), 1);
        tick();                                    // T+4: back in IDLE
        chk("wr_idle_rspv",   32'(rsp_valid_o), 0);
        chk("wr_idle_cmdrdy", 32'(cmd_ready_o), 1);

        // Read 0x010 with 3 wait states; command wdata/strb must not reach the bus
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0010;
        cmd_wdata_i = 32'hDEAD_BEEF; cmd_strb_i = 4'hF;
        pready_i = 1'b0; prdata_i = 32'hFFFF_FFFF;
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("rd_pstrb",   32'(pstrb_o), 0);
            chk("rd_penable", 32'(penable_o), (i >= 2 && i <= 5) ? 1 : 0);
            chk("rd_rspv",    32'(rsp_valid_o), (i == 6) ? 1 : 0);
            if (i == 1) chk("rd_pwdata", pwdata_o, 0);
            if (i == 5) begin
                pready_i = 1'b1; prdata_i = 32'h1234_5678;
            end
            if (i == 6) begin
                chk("rd_rdata", rsp_rdata_o, 32'h1234_5678);
                chk("rd_err",   32'(rsp_err_o), 0);
                chk("rd_txn",   32'(txn_cnt_o), 2);
                pready_i = 1'b0; prdata_i = '0;
            end
            if (i < 6) tick();
        end
        tick();

        // Read with slave error; response held for 5 cycles while next command waits
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0020;
        rsp_ready_i = 1'b0;
        tick();                                    // T+1 SETUP
        cmd_write_i = 1'b1; cmd_addr_i = 16'h0030;
        cmd_wdata_i = 32'hCAFE_F00D; cmd_strb_i = 4'h3;
        tick();                                    // T+2 ACCESS
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hAAAA_5555;
        tick();                                    // T+3 RESP
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
        chk("se_err",     32'(rsp_err_o), 1);
        chk("se_tmo",     32'(rsp_timeout_o), 0);
        chk("se_rdata",   rsp_rdata_o, 32'hAAAA_5555);
        chk("se_err_cnt", 32'(err_cnt_o), 1);
        chk("se_txn",     32'(txn_cnt_o), 3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_cmdrdy", 32'(cmd_ready_o), 0);
            chk("hold_psel",   32'(psel_o), 0);
            chk("hold_rspv",   32'(rsp_valid_o), 1);
            chk("hold_err",    32'(rsp_err_o), 1);
            if (i == 4) rsp_ready_i = 1'b1;
            tick();
        end
        chk("hs_rspv",   32'(rsp_valid_o), 0);
        chk("hs_cmdrdy", 32'(cmd_ready_o), 1);
        chk("hs_psel",   32'(psel_o), 0);
        tick();                                    // next command in SETUP
        cmd_valid_i = 1'b0;
        chk("nx_psel",   32'(psel_o), 1);
        chk("nx_pwrite", 32'(pwrite_o), 1);
        chk("nx_paddr",  32'(paddr_o), 32'h30);
        chk("nx_pwdata", pwdata_o, 32'hCAFE_F00D);
        chk("nx_pstrb",  32'(pstrb_o), 32'h3);
        tick();                                    // ACCESS, pready low

        // Reset during ACCESS
        chk("pre_rst_penable", 32'(penable_o), 1);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_psel",    32'(psel_o), 0);
        chk("mid_rst_penable", 32'(penable_o), 0);
        chk("mid_rst_rspv",    32'(rsp_valid_o), 0);
        chk("mid_rst_txn",     32'(txn_cnt_o), 0);
        chk("mid_rst_err",     32'(err_cnt_o), 0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_cmdrdy", 32'(cmd_ready_o), 1);

        // pready stuck low
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0040;
        rsp_ready_i = 1'b1; prdata_i = 32'h5A5A_5A5A;
        tick();                                    // T+1 SETUP
        cmd_valid_i = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("stk_penable", 32'(penable_o), 1);
            chk("stk_rspv",    32'(rsp_valid_o), 0);
        end
        tick();                                    // T+6
`ifdef MATMUL_APB_TIMEOUT_EN
        chk("tmo_psel",    32'(psel_o), 0);
        chk("tmo_penable", 32'(penable_o), 0);
        chk("tmo_rspv",    32'(rsp_valid_o), 1);
        chk("tmo_err",     32'(rsp_err_o), 1);
        chk("tmo_flag",    32'(rsp_timeout_o), 1);
        chk("tmo_rdata",   rsp_rdata_o, 0);
        chk("tmo_err_cnt", 32'(err_cnt_o), 1);
        chk("tmo_txn",     32'(txn_cnt_o), 0);
        tick();
        chk("tmo_idle_cmdrdy", 32'(cmd_ready_o), 1);
`else
        for (int i = 0; i < 4; i++) begin
            chk("wait_psel",    32'(psel_o), 1);
            chk("wait_penable", 32'(penable_o), 1);
            chk("wait_rspv",    32'(rsp_valid_o), 0);
            chk("wait_tmo",     32'(rsp_timeout_o), 0);
            tick();
        end
        pready_i = 1'b1;
        tick();
        pready_i = 1'b0;
        chk("wait_done_rspv",  32'(rsp_valid_o), 1);
        chk("wait_done_rdata", rsp_rdata_o, 32'h5A5A_5A5A);
        chk("wait_done_txn",   32'(txn_cnt_o), 1);
        chk("wait_done_errc",  32'(err_cnt_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
